pwm_frame_ctrl: RTL and testbench
=================================

Name: pwm_frame_ctrl

Overview:
Sequencer and configuration front-end for a bank of NUM_CH pwm channels. It generates the shared clk_tick pulse and the pwmclk frame-start pulse from the system clock, and holds a byte-addressed duty register file. Duty values are committed atomically in 16-bit pairs and transferred to the channels only at frame boundaries, so no channel sees a torn duty mid-pulse. A frame-count watchdog and an arm bit force all duties to 0 (output low) when the host stops updating or disarms.

Parameters:
NUM_CH, 8, number of pwm channels driven (1..15)
TICK_DIV, 50, clk cycles per clk_tick (>=2)
FRAME_TICKS, 2500, clk_tick periods per pwm frame (>=2)
WDOG_FRAMES, 40, frames without a duty commit before timeout (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
wr_en  in  1  single-cycle register write strobe
wr_addr  in  5  byte address
wr_data  in  8  write data
clk_tick  out  1  one-clk pulse every TICK_DIV clks, to all channels
pwmclk  out  1  one-clk frame-start pulse, to all channels
pwm_duty_l  out  8*NUM_CH  active duty low bytes; channel n at [8n+7:8n]
pwm_duty_h  out  8*NUM_CH  active duty high bytes; same packing
armed  out  1  arm bit state
timeout  out  1  watchdog expired (sticky)

Behaviour:
- Reset values: clk_tick=0, pwmclk=0, all duty outputs 0, armed=0, timeout=0; prescaler, frame counter, watchdog counter, staging and shadow registers all 0.
- Prescaler counts 0..TICK_DIV-1; clk_tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0. clk_tick is registered.
- Frame counter advances only on clk_tick, counting 0..FRAME_TICKS-1. pwmclk=1 in the same cycle as the clk_tick on which the counter equals FRAME_TICKS-1; the counter then wraps. pwmclk is always coincident with a clk_tick and is exactly 1 clk wide.
- Address map: addr = 2n writes the low byte of channel n into a per-channel staging register, with no other effect. addr = 2n+1 commits shadow[n] = {wr_data, staged_low[n]} in one cycle; that write is a "commit". addr 5'h1E is the control register: bit0 sets arm, and writing bit1=1 clears timeout (self-clearing). Writes to any other address, or to n >= NUM_CH, are ignored.
- Frame transfer: in the cycle pwmclk=1, active duty outputs update on the next edge:
  - to shadow[n] if armed=1 and timeout=0;
  - to 0 otherwise.
- A commit in the same cycle as pwmclk is not included in that transfer; it applies at the following frame.
- Disarm (write to the control register with bit0=0): all active duty outputs go to 0 on the next edge, immediately rather than at the frame boundary. Shadow registers are retained. Re-arming takes effect at the next pwmclk.
- Watchdog counts pwmclk pulses since the last commit.
  - Any commit resets the count to 0; a commit coincident with pwmclk also gives count 0 (commit wins).
  - When the count reaches WDOG_FRAMES, timeout goes to 1 and the active duties go to 0 in that same transfer.
  - timeout is sticky: a commit alone does not clear it; only the bit1 clear does. The clear takes effect the cycle after the write, and duties return at the next pwmclk.
  - The count saturates at WDOG_FRAMES.
  - The watchdog counts only while armed=1 and holds at 0 while disarmed.
- A write to the control register coincident with pwmclk: the arm value is sampled before the write (the old arm state governs the transfer). The exception is disarm, which always forces 0 on the next edge.
- Asynchronous reset mid-frame returns every output to its reset value. The first pwmclk after reset release occurs TICK_DIV*FRAME_TICKS clks later.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - address constants: ADDR_CTRL=5'h1E;
  - control bit indices: CTRL_ARM=0, CTRL_TO_CLR=1;
  - a duty-pair width constant DUTY_W=16.
- One sub-module, pwm_tick_gen, contains the prescaler and frame counter and outputs clk_tick/pwmclk. The top level contains the register file, transfer logic and watchdog.

Test Plan:
All scenarios use TICK_DIV=4, FRAME_TICKS=10, WDOG_FRAMES=3, NUM_CH=8.
1. Timing after reset: clk_tick every 4 clks. First pwmclk at clk 40 after release, coincident with clk_tick, 1 clk wide, then every 40 clks.
2. Atomic commit: arm. Write ch2 low=0x34 (addr 4), wait past one pwmclk, then write high=0x12 (addr 5). ch2 stays 0 until the first pwmclk after the high write, then equals 0x1234 on both byte outputs.
3. Same-cycle commit: commit ch0=0x0100 on the pwmclk cycle. ch0 is unchanged at that frame and becomes 0x0100 at the next frame.
4. Watchdog: armed, ch1=0x0200, then no further commits. timeout rises on the 3rd subsequent pwmclk and ch1 goes to 0 in that transfer. A commit alone leaves ch1=0. Writing ctrl=0x03 clears timeout, and ch1 returns at the next pwmclk.
5. Disarm: armed with nonzero duties, write ctrl=0x00 mid-frame. All duty outputs are 0 on the next edge and armed=0. Writing ctrl=0x01 restores the shadow values at the next pwmclk.
6. Ignored writes: writes to addr 0x10..0x1D and 0x1F change no outputs or registers. Asserting resetn=0 mid-frame returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared constants for the pwm frame controller: control register address,
// control bit positions and the committed duty width.
package pwm_ctrl_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h1E;
  localparam int         CTRL_ARM    = 0;
  localparam int         CTRL_TO_CLR = 1;
  localparam int         DUTY_W      = 16;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and frame counter: produces the registered clk_tick pulse and the
// frame-start pwmclk pulse, which always coincides with a clk_tick.
module pwm_tick_gen #(
  parameter int TICK_DIV    = 50,
  parameter int FRAME_TICKS = 2500
) (
  input  logic clk,
  input  logic resetn,
  output logic clk_tick,
  output logic pwmclk
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FRAME_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          tick_q, tick_d;
  logic          pwm_q, pwm_d;

  // Pulses are decoded one cycle early so they can be registered yet line up
  // with the terminal counts; frame_q cannot change in the cycle before a tick.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PRESC_LAST);
    frame_d = frame_q;
    if (tick_q) begin
      frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
    end
    pwm_d = tick_d && (frame_q == FRAME_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
    end
  end

  assign clk_tick = tick_q;
  assign pwmclk   = pwm_q;

endmodule

// File: rtl/pwm_frame_ctrl.sv
// Duty register file, frame-boundary transfer and frame-count watchdog for a
// bank of pwm channels; tick/frame timing comes from pwm_tick_gen.
module pwm_frame_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int TICK_DIV    = 50,
  parameter int FRAME_TICKS = 2500,
  parameter int WDOG_FRAMES = 40
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [7:0]          wr_data,
  output logic                clk_tick,
  output logic                pwmclk,
  output logic [8*NUM_CH-1:0] pwm_duty_l,
  output logic [8*NUM_CH-1:0] pwm_duty_h,
  output logic                armed,
  output logic                timeout
);

  localparam int WW = $clog2(WDOG_FRAMES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_FRAMES - 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_FRAMES);

  logic tick, frame;

  pwm_tick_gen #(
    .TICK_DIV   (TICK_DIV),
    .FRAME_TICKS(FRAME_TICKS)
  ) u_tick_gen (
    .clk     (clk),
    .resetn  (resetn),
    .clk_tick(tick),
    .pwmclk  (frame)
  );

  logic [7:0]    stage_q  [NUM_CH];
  logic [7:0]    stage_d  [NUM_CH];
  duty_t         shadow_q [NUM_CH];
  duty_t         shadow_d [NUM_CH];
  duty_t         duty_q   [NUM_CH];
  duty_t         duty_d   [NUM_CH];
  logic          armed_q, armed_d;
  logic          timeout_q, timeout_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic [3:0] wr_ch;
  logic       ch_wr, commit, ctrl_wr, disarm, wdog_hit, xfer_en;

  // Channel 15 would alias the control register, so NUM_CH <= 15 keeps the
  // channel decode and the control decode disjoint.
  assign wr_ch    = wr_addr[4:1];
  assign ch_wr    = wr_en && (int'(wr_ch) < NUM_CH);
  assign commit   = ch_wr && wr_addr[0];
  assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
  assign disarm   = ctrl_wr && !wr_data[CTRL_ARM];
  assign wdog_hit = frame && armed_q && !commit && (wdog_q == WDOG_LAST);
  assign xfer_en  = armed_q && !timeout_q && !wdog_hit;

  always_comb begin
    stage_d  = stage_q;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_wr && !wr_addr[0] && (wr_ch == 4'(n))) begin
        stage_d[n] = wr_data;
      end
      if (commit && (wr_ch == 4'(n))) begin
        shadow_d[n] = {wr_data, stage_q[n]};
      end
      // Transfer reads shadow_q, so a commit on the frame cycle waits a frame.
      if (disarm) begin
        duty_d[n] = '0;
      end else if (frame) begin
        duty_d[n] = xfer_en ? shadow_q[n] : '0;
      end
    end
  end

  always_comb begin
    armed_d = ctrl_wr ? wr_data[CTRL_ARM] : armed_q;

    timeout_d = timeout_q;
    if (ctrl_wr && wr_data[CTRL_TO_CLR]) begin
      timeout_d = 1'b0;
    end else if (wdog_hit) begin
      timeout_d = 1'b1;
    end

    wdog_d = wdog_q;
    if (!armed_q || commit) begin
      wdog_d = '0;
    end else if (frame && (wdog_q != WDOG_MAX)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q   <= '{default: '0};
      shadow_q  <= '{default: '0};
      duty_q    <= '{default: '0};
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      duty_q    <= duty_d;
      armed_q   <= armed_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_duty_out
    assign pwm_duty_l[8*n +: 8] = duty_q[n][7:0];
    assign pwm_duty_h[8*n +: 8] = duty_q[n][15:8];
  end

  assign clk_tick = tick;
  assign pwmclk   = frame;
  assign armed    = armed_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Bench for pwm_frame_ctrl: directed vector table, hand sequences for timing
// and reset, and randomized writes checked cycle-by-cycle against a model.
module tb_pwm_frame_ctrl;

  localparam int NUM_CH      = 8;
  localparam int TICK_DIV    = 4;
  localparam int FRAME_TICKS = 10;
  localparam int WDOG_FRAMES = 3;
  localparam int FRAME_CLKS  = TICK_DIV * FRAME_TICKS;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                wr_en = 1'b0;
  logic [4:0]          wr_addr = '0;
  logic [7:0]          wr_data = '0;
  logic                clk_tick, pwmclk, armed, timeout;
  logic [8*NUM_CH-1:0] pwm_duty_l, pwm_duty_h;

  int checks = 0;
  int failures = 0;

  pwm_frame_ctrl #(
    .NUM_CH     (NUM_CH),
    .TICK_DIV   (TICK_DIV),
    .FRAME_TICKS(FRAME_TICKS),
    .WDOG_FRAMES(WDOG_FRAMES)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clk_tick  (clk_tick),
    .pwmclk    (pwmclk),
    .pwm_duty_l(pwm_duty_l),
    .pwm_duty_h(pwm_duty_h),
    .armed     (armed),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: k counts clock edges since reset release; the frame
  // pulse falls on the last clock of every FRAME_CLKS-long frame.
  int          k;
  bit          m_armed, m_to;
  int          m_frames;
  logic [7:0]  m_stg  [NUM_CH];
  logic [15:0] m_sh   [NUM_CH];
  logic [15:0] m_duty [NUM_CH];

  task automatic model_reset();
    k = 0; m_armed = 0; m_to = 0; m_frames = 0;
    for (int n = 0; n < NUM_CH; n++) begin
      m_stg[n] = '0; m_sh[n] = '0; m_duty[n] = '0;
    end
  endtask

  task automatic model_edge(input bit en, input logic [4:0] a, input logic [7:0] d);
    bit p, ch_wr, commit, ctrl, expire;
    int ch;
    logic [15:0] nd [NUM_CH];
    p      = (k % FRAME_CLKS) == FRAME_CLKS - 1;
    ch     = int'(a) / 2;
    ch_wr  = en && (ch < NUM_CH);
    commit = ch_wr && a[0];
    ctrl   = en && (a == 5'h1E);
    expire = p && m_armed && !commit && (m_frames == WDOG_FRAMES - 1);
    nd = m_duty;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ctrl && !d[0]) nd[n] = '0;
      else if (p) nd[n] = (m_armed && !m_to && !expire) ? m_sh[n] : 16'h0;
    end
    if (!m_armed || commit) m_frames = 0;
    else if (p && m_frames < WDOG_FRAMES) m_frames++;
    if (ctrl && d[1]) m_to = 0;
    else if (expire) m_to = 1;
    if (ctrl) m_armed = d[0];
    if (commit) m_sh[ch] = {d, m_stg[ch]};
    else if (ch_wr) m_stg[ch] = d;
    m_duty = nd;
    k++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic compare_all();
    logic [8*NUM_CH-1:0] el, eh;
    for (int n = 0; n < NUM_CH; n++) begin
      el[8*n +: 8] = m_duty[n][7:0];
      eh[8*n +: 8] = m_duty[n][15:8];
    end
    check("clk_tick", 64'(clk_tick), 64'((k % TICK_DIV) == TICK_DIV - 1));
    check("pwmclk", 64'(pwmclk), 64'((k % FRAME_CLKS) == FRAME_CLKS - 1));
    check("armed", 64'(armed), 64'(m_armed));
    check("timeout", 64'(timeout), 64'(m_to));
    check("duty_l", 64'(pwm_duty_l), 64'(el));
    check("duty_h", 64'(pwm_duty_h), 64'(eh));
  endtask

  task automatic cyc(input bit en, input logic [4:0] a, input logic [7:0] d);
    wr_en = en; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_edge(en, a, d);
    #1;
    compare_all();
    wr_en = 1'b0;
  endtask

  task automatic wait_pwm();
    int n = 0;
    while (pwmclk !== 1'b1 && n < FRAME_CLKS + 2) begin
      cyc(1'b0, 5'h0, 8'h0);
      n++;
    end
    check("pwmclk_wait", 64'(pwmclk), 64'd1);
  endtask

  task automatic to_frame();
    wait_pwm();
    cyc(1'b0, 5'h0, 8'h0);
  endtask

  typedef struct packed {
    bit          sync;
    bit          en;
    logic [4:0]  addr;
    logic [7:0]  data;
    bit          frame;
    logic [3:0]  ch;
    logic [15:0] exp_duty;
    bit          exp_armed;
    bit          exp_to;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int first_pwm, second_pwm;
    logic [15:0] exp_ch [NUM_CH];

    // sync,en,addr,data,frame,ch,exp_duty,exp_armed,exp_to
    tbl[0]  = '{1'b0, 1'b1, 5'h1E, 8'h01, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'h04, 8'h34, 1'b1, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 5'h05, 8'h12, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd2, 16'h1234, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'h00, 8'h00, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 5'h01, 8'h01, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd0, 16'h0100, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 5'h02, 8'h00, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'h03, 8'h02, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd1, 16'h0200, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd1, 16'h0200, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 5'h03, 8'h02, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 5'h1E, 8'h03, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd1, 16'h0200, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 4'd2, 16'h1234, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 5'h1E, 8'h00, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 5'h1E, 8'h01, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 4'd2, 16'h1234, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 4'd0, 16'h0100, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 4'd1, 16'h0200, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_tick", 64'(clk_tick), 64'd0);
    check("rst_pwmclk", 64'(pwmclk), 64'd0);
    check("rst_duty_l", 64'(pwm_duty_l), 64'd0);
    check("rst_duty_h", 64'(pwm_duty_h), 64'd0);
    check("rst_armed", 64'(armed), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    #1 resetn = 1'b1;
    model_reset();

    // Timing after release: pwmclk in the 40th clock period, then every 40
    first_pwm = -1; second_pwm = -1;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      cyc(1'b0, 5'h0, 8'h0);
      if (pwmclk === 1'b1) begin
        if (first_pwm < 0) first_pwm = k;
        else if (second_pwm < 0) second_pwm = k;
      end
    end
    check("first_pwmclk_edge", 64'(first_pwm), 64'(FRAME_CLKS - 1));
    check("second_pwmclk_edge", 64'(second_pwm), 64'(2 * FRAME_CLKS - 1));

    // Directed vectors: atomic commit, same-cycle commit, watchdog, disarm
    for (int i = 0; i < 21; i++) begin
      int c;
      c = int'(tbl[i].ch);
      if (tbl[i].sync) wait_pwm();
      cyc(tbl[i].en, tbl[i].addr, tbl[i].data);
      if (tbl[i].frame) to_frame();
      check($sformatf("vec%0d_duty_l", i), 64'(pwm_duty_l[8*c +: 8]), 64'(tbl[i].exp_duty[7:0]));
      check($sformatf("vec%0d_duty_h", i), 64'(pwm_duty_h[8*c +: 8]), 64'(tbl[i].exp_duty[15:8]));
      check($sformatf("vec%0d_armed", i), 64'(armed), 64'(tbl[i].exp_armed));
      check($sformatf("vec%0d_timeout", i), 64'(timeout), 64'(tbl[i].exp_to));
    end

    // Ignored addresses must not disturb anything, even across a frame
    for (int a = 5'h10; a <= 5'h1F; a++) begin
      if (a != 5'h1E) cyc(1'b1, 5'(a), 8'hFF);
    end
    to_frame();
    exp_ch = '{16'h0100, 16'h0200, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int n = 0; n < NUM_CH; n++) begin
      check($sformatf("ignored_ch%0d", n),
            64'({pwm_duty_h[8*n +: 8], pwm_duty_l[8*n +: 8]}), 64'(exp_ch[n]));
    end
    check("ignored_armed", 64'(armed), 64'd1);
    check("ignored_timeout", 64'(timeout), 64'd0);

    // Asynchronous reset mid-frame
    repeat (5) cyc(1'b0, 5'h0, 8'h0);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_duty_l", 64'(pwm_duty_l), 64'd0);
    check("async_rst_duty_h", 64'(pwm_duty_h), 64'd0);
    check("async_rst_armed", 64'(armed), 64'd0);
    check("async_rst_timeout", 64'(timeout), 64'd0);
    check("async_rst_tick", 64'(clk_tick), 64'd0);
    check("async_rst_pwmclk", 64'(pwmclk), 64'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    model_reset();

    // Randomized writes with varying density against the model
    for (int seg = 0; seg < 8; seg++) begin
      int pct;
      case (seg % 4)
        0: pct = 25;
        1: pct = 0;
        2: pct = 3;
        default: pct = 60;
      endcase
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 99) < pct) begin
          int r;
          logic [4:0] a;
          logic [7:0] d;
          r = $urandom_range(0, 9);
          d = 8'($urandom);
          if (r < 6) begin
            a = 5'($urandom_range(0, 2 * NUM_CH - 1));
          end else if (r < 8) begin
            a = 5'h1E;
            d[0] = ($urandom_range(0, 7) != 0);
          end else begin
            a = 5'($urandom_range(16, 31));
          end
          cyc(1'b1, a, d);
        end else begin
          cyc(1'b0, 5'h0, 8'h0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
